// File: rtl/csr_apb_arbiter.sv
// csr_apb_arbiter: two-requester round-robin APB master front-end
// for the CSR slave; one transfer in flight, per-transfer timeout.
module csr_apb_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  pclk,
   input  logic                  hrst,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_gnt,
   output logic                  req0_done,
   output logic                  req0_err,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_gnt,
   output logic                  req1_done,
   output logic                  req1_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Abort fires on the last allowed low-ready ACCESS cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  owner_q, owner_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            done_q, done_d;
   logic [1:0]            err_q, err_d;

   logic any_v;
   logic pick1;
   logic take;
   logic acc_ok;
   logic acc_to;
   logic fin;

   // Round-robin pick: on a tie the side that did not win last goes.
   always_comb begin
      any_v = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         pick1 = ~last_q;
      end else begin
         pick1 = req1_valid;
      end
      take = (state_q == IDLE) && any_v && !hrst;
   end

   // Transfer ends on pready or when the wait budget runs out.
   always_comb begin
      acc_ok = (state_q == ACCESS) && pready;
      acc_to = (state_q == ACCESS) && !pready
               && (cnt_q == TO_LAST);
      fin    = acc_ok | acc_to;
   end

   // FSM state register.
   always_ff @(posedge pclk or posedge hrst) begin
      if (hrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (take) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (fin) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: grant pulse and APB phase strobes.
   always_comb begin
      req0_gnt = take & ~pick1;
      req1_gnt = take & pick1;
      psel     = (state_q != IDLE);
      penable  = (state_q == ACCESS);
      busy     = (state_q != IDLE);
   end

   // Datapath next values: latch on grant, report on completion.
   always_comb begin
      owner_d  = owner_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rdata_d  = rdata_q;
      last_d   = last_q;
      cnt_d    = 8'd0;
      done_d   = 2'b00;
      err_d    = 2'b00;
      if (take) begin
         owner_d = pick1;
         if (pick1) begin
            pwrite_d = req1_write;
            paddr_d  = req1_addr;
            pwdata_d = req1_wdata;
         end else begin
            pwrite_d = req0_write;
            paddr_d  = req0_addr;
            pwdata_d = req0_wdata;
         end
      end
      if ((state_q == ACCESS) && !pready && !acc_to) begin
         cnt_d = cnt_q + 8'd1;
      end
      if (fin) begin
         done_d[owner_q] = 1'b1;
         err_d[owner_q]  = acc_to;
         last_d          = owner_q;
      end
      if (acc_ok) begin
         rdata_d = pwrite_q ? '0 : prdata;
      end else if (acc_to) begin
         rdata_d = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge pclk or posedge hrst) begin
      if (hrst) begin
         cnt_q    <= 8'd0;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         done_q   <= 2'b00;
         err_q    <= 2'b00;
      end else begin
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_rdata = rdata_q;
   assign req0_done = done_q[0];
   assign req1_done = done_q[1];
   assign req0_err  = err_q[0];
   assign req1_err  = err_q[1];

endmodule

// File: tb/tb_csr_apb_arbiter.sv
// tb_csr_apb_arbiter: directed plan scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_csr_apb_arbiter;

   localparam int TO = 16;

   logic        pclk = 1'b0;
   logic        hrst;
   logic        rv [2];
   logic        rw [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];
   logic        g0, g1, d0, d1, e0, e1;
   logic [31:0] rsp;
   logic        busy, psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata;
   logic        pready;

   csr_apb_arbiter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .TIMEOUT_CYC(TO)
   ) dut (
      .pclk      (pclk),
      .hrst      (hrst),
      .req0_valid(rv[0]),
      .req0_write(rw[0]),
      .req0_addr (ra[0]),
      .req0_wdata(rd[0]),
      .req0_gnt  (g0),
      .req0_done (d0),
      .req0_err  (e0),
      .req1_valid(rv[1]),
      .req1_write(rw[1]),
      .req1_addr (ra[1]),
      .req1_wdata(rd[1]),
      .req1_gnt  (g1),
      .req1_done (d1),
      .req1_err  (e1),
      .rsp_rdata (rsp),
      .busy      (busy),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int          cyc;
      int          id;
      bit          err;
      logic [31:0] rd;
   } ev_t;

   ev_t gq[$];
   ev_t dq[$];

   // Transaction model: one transfer in flight, aged in cycles.
   bit          m_inf;
   int          m_own, m_age, m_low, m_waits, m_last, m_gw;
   logic        m_wr;
   logic [31:0] m_addr, m_wdat, m_rdat;
   bit          m_done [2];
   bit          m_err  [2];
   bit          gprev  [2];

   int cyc, errors, checks, pen_cnt, next_waits;
   int pend [2];
   bit rand_en;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_inf  = 0;
      m_last = 1;
      m_age  = 0;
      m_low  = 0;
      m_wr   = 0;
      m_addr = 0;
      m_wdat = 0;
      m_rdat = 0;
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 0;
         m_err[i]  = 0;
         gprev[i]  = 0;
      end
   endtask

   task automatic new_payload(input int i);
      rw[i] = 1'($urandom % 2);
      ra[i] = $urandom & 32'hFC;
      rd[i] = $urandom;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 2; i++) begin
         if (rand_en) begin
            if (rv[i] && gprev[i]) begin
               rv[i] = 1'($urandom % 2);
               new_payload(i);
            end else if (rv[i]) begin
               if ($urandom % 16 == 0) rv[i] = 0;
            end else if ($urandom % 3 == 0) begin
               rv[i] = 1;
               new_payload(i);
            end
         end else if (gprev[i]) begin
            if (pend[i] > 0) begin
               pend[i]--;
               new_payload(i);
            end else begin
               rv[i] = 0;
            end
         end
      end
      if (m_inf && m_age >= 2) pready = (m_low >= m_waits);
      else pready = 1'($urandom % 2);
      prdata = rand_en ? $urandom : 32'hDEADBEEF;
   endtask

   task automatic check_cycle();
      m_gw = -1;
      if (!hrst && !m_inf && (rv[0] || rv[1])) begin
         if (rv[0] && rv[1]) m_gw = 1 - m_last;
         else m_gw = rv[0] ? 0 : 1;
      end
      chk("gnt0", g0, m_gw == 0);
      chk("gnt1", g1, m_gw == 1);
      chk("psel", psel, m_inf);
      chk("penable", penable, m_inf && m_age >= 2);
      chk("busy", busy, m_inf);
      chk("paddr", paddr, m_addr);
      chk("pwdata", pwdata, m_wdat);
      chk("pwrite", pwrite, m_wr);
      chk("done0", d0, m_done[0]);
      chk("done1", d1, m_done[1]);
      chk("err0", e0, m_err[0]);
      chk("err1", e1, m_err[1]);
      chk("rsp_rdata", rsp, m_rdat);
      if (penable) pen_cnt++;
   endtask

   task automatic model_update();
      bit          fin  = 0;
      bit          ferr = 0;
      logic [31:0] fval = 0;
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 0;
         m_err[i]  = 0;
         gprev[i]  = 0;
      end
      if (m_inf) begin
         if (m_age >= 2) begin
            if (pready) begin
               fin  = 1;
               fval = m_wr ? 32'h0 : prdata;
            end else begin
               m_low++;
               if (m_low == TO) begin
                  fin  = 1;
                  ferr = 1;
               end
            end
         end else begin
            m_age = 2;
         end
         if (fin) begin
            m_done[m_own] = 1;
            m_err[m_own]  = ferr;
            m_rdat        = fval;
            m_inf         = 0;
            m_last        = m_own;
            dq.push_back('{cyc + 1, m_own, ferr, fval});
         end
      end else if (m_gw >= 0) begin
         m_inf  = 1;
         m_age  = 1;
         m_low  = 0;
         m_own  = m_gw;
         m_wr   = rw[m_gw];
         m_addr = ra[m_gw];
         m_wdat = rd[m_gw];
         if (rand_en) begin
            m_waits = ($urandom % 16 == 0) ? 40 : int'($urandom % 4);
         end else begin
            m_waits = next_waits;
         end
         gprev[m_gw] = 1;
         gq.push_back('{cyc, m_gw, 1'b0, 32'h0});
      end
   endtask

   task automatic cycle();
      drive_inputs();
      @(negedge pclk);
      check_cycle();
      if (hrst) model_reset();
      else model_update();
      @(posedge pclk);
      #1;
      cyc++;
   endtask

   task automatic run_idle(input string nm, input int maxc);
      int n = 0;
      while ((m_inf || rv[0] || rv[1]) && n < maxc) begin
         cycle();
         n++;
      end
      chk({nm, "_bound"}, 32'(m_inf || rv[0] || rv[1]), 0);
      cycle();
   endtask

   task automatic req(input int i, input bit w,
                      input logic [31:0] a, input logic [31:0] d);
      rv[i] = 1;
      rw[i] = w;
      ra[i] = a;
      rd[i] = d;
   endtask

   task automatic ev_chk(input string nm, input int k, input int id,
                         input int lat, input bit err,
                         input logic [31:0] rdv, input bit use_rd);
      if (k >= gq.size() || k >= dq.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: event %0d missing, got %0d/%0d want more",
                  nm, k, gq.size(), dq.size());
      end else begin
         chk({nm, "_gid"}, gq[k].id, id);
         chk({nm, "_did"}, dq[k].id, id);
         chk({nm, "_lat"}, dq[k].cyc - gq[k].cyc, lat);
         chk({nm, "_err"}, dq[k].err, err);
         if (use_rd) chk({nm, "_rd"}, dq[k].rd, rdv);
      end
   endtask

   task automatic clr_ev();
      gq.delete();
      dq.delete();
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      cyc        = 0;
      pen_cnt    = 0;
      next_waits = 0;
      rand_en    = 0;
      pend[0]    = 0;
      pend[1]    = 0;
      hrst       = 1;
      prdata     = 0;
      pready     = 0;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 0;
         rw[i] = 0;
         ra[i] = 0;
         rd[i] = 0;
      end
      model_reset();
      #2;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rdata", rsp, 0);
      chk("rst_done", {d0, d1, e0, e1}, 0);
      @(posedge pclk);
      #1;
      hrst = 0;

      // Zero-wait write from req0.
      clr_ev();
      req(0, 1, 32'h04, 32'hC2);
      cycle();
      chk("s1_c1_psel", psel, 1);
      chk("s1_c1_penable", penable, 0);
      cycle();
      chk("s1_c2_psel", psel, 1);
      chk("s1_c2_penable", penable, 1);
      run_idle("s1", 20);
      ev_chk("s1", 0, 0, 3, 0, 0, 0);
      chk("s1_paddr", paddr, 32'h04);
      chk("s1_pwdata", pwdata, 32'hC2);

      // Zero-wait read from req1.
      clr_ev();
      req(1, 0, 32'h00, 32'h0);
      run_idle("s2", 20);
      ev_chk("s2", 0, 1, 3, 0, 32'hDEADBEEF, 1);
      chk("s2_rsp", rsp, 32'hDEADBEEF);

      // Three back-to-back ties: order 0,1,0.
      clr_ev();
      pend[0] = 1;
      req(0, 1, 32'h08, 32'h1);
      req(1, 1, 32'h0C, 32'h2);
      run_idle("s3", 40);
      ev_chk("s3a", 0, 0, 3, 0, 0, 0);
      ev_chk("s3b", 1, 1, 3, 0, 0, 0);
      ev_chk("s3c", 2, 0, 3, 0, 0, 0);
      if (gq.size() == 3) begin
         chk("s3_gap1", gq[1].cyc - gq[0].cyc, 3);
         chk("s3_gap2", gq[2].cyc - gq[1].cyc, 3);
      end else begin
         chk("s3_ngnt", gq.size(), 3);
      end

      // Two wait states.
      clr_ev();
      next_waits = 2;
      pen_cnt    = 0;
      req(0, 1, 32'h08, 32'h55);
      run_idle("s4", 30);
      ev_chk("s4", 0, 0, 5, 0, 0, 0);
      chk("s4_penable_cycles", pen_cnt, 3);

      // Stuck pready: timeout, then a normal read.
      clr_ev();
      next_waits = 1000;
      req(0, 0, 32'h04, 32'h0);
      run_idle("s5", 40);
      ev_chk("s5", 0, 0, 18, 1, 32'h0, 1);
      chk("s5_rsp", rsp, 32'h0);
      chk("s5_psel", psel, 0);
      next_waits = 0;
      req(0, 0, 32'h00, 32'h0);
      run_idle("s5b", 20);
      ev_chk("s5b", 1, 0, 3, 0, 32'hDEADBEEF, 1);

      // Reset in ACCESS, then a tie must go to req0.
      clr_ev();
      next_waits = 5;
      req(1, 1, 32'h04, 32'h7);
      cycle();
      cycle();
      chk("s6_in_access", penable, 1);
      #2;
      hrst = 1;
      #1;
      chk("s6_rst_psel", psel, 0);
      chk("s6_rst_penable", penable, 0);
      chk("s6_rst_busy", busy, 0);
      model_reset();
      rv[0] = 0;
      rv[1] = 0;
      @(posedge pclk);
      #1;
      cycle();
      cycle();
      hrst = 0;
      clr_ev();
      next_waits = 0;
      req(0, 0, 32'h00, 32'h0);
      req(1, 0, 32'h04, 32'h0);
      run_idle("s6", 40);
      ev_chk("s6a", 0, 0, 3, 0, 32'hDEADBEEF, 1);
      ev_chk("s6b", 1, 1, 3, 0, 32'hDEADBEEF, 1);

      // Random traffic against the model.
      rand_en = 1;
      for (int n = 0; n < 3000; n++) begin
         cycle();
      end
      rand_en = 0;
      run_idle("drain", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
